// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline hazard/forwarding logic.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: forward-select encodings, MDU busy FSM state type, register $0.
package mips_pkg;

  // EX-stage source mux selects
  localparam logic [1:0] FWD_REGF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB   = 2'b01;  // operand from result_W
  localparam logic [1:0] FWD_MEM  = 2'b10;  // operand from aluout_M

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_busy_ctr.sv
// MDU occupancy tracker: IDLE/BUSY FSM with a countdown of MDU_LATENCY cycles.
// Latency: busy rises the cycle after start; done pulses on the last BUSY cycle.
// Backpressure: none; start while BUSY is ignored (upstream stall logic prevents it).
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start        - EX holds a mult/div this cycle
//   busy         - FSM is in BUSY
//   done         - last BUSY cycle (cnt == 0)
module mdu_busy_ctr
  import mips_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done
);

  // Count runs MDU_LATENCY-1 down to 0, giving exactly MDU_LATENCY BUSY cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MDU_BUSY: begin
        // A start seen here is deliberately not honoured: no restart of the count.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MDU_BUSY);
  assign done = busy && (cnt_q == '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline (forward selects, stall/flush).
// Latency: forwarding and stall/flush are combinational; MDU busy/done are registered state.
// Backpressure: stall_F/stall_D hold IF/ID and flush_E bubbles EX on load-use, branch or MDU hazards.
//
// Ports: rs/rt per stage, writereg/regwrite/memtoreg per stage, branch_D, mdu_use_D, mdu_start_E in;
//        forward_a/b_E (2b), forward_a/b_D (1b), stall_F, stall_D, flush_E, mdu_busy, mdu_done out.
// Optional: define HAZARD_STATS_EN to add saturating stall_cnt / fwd_cnt outputs.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] writereg_E,
  input  logic [4:0] writereg_M,
  input  logic [4:0] writereg_W,
  input  logic       regwrite_E,
  input  logic       regwrite_M,
  input  logic       regwrite_W,
  input  logic       memtoreg_E,
  input  logic       memtoreg_M,
  input  logic       branch_D,
  input  logic       mdu_use_D,
  input  logic       mdu_start_E,
  output logic [1:0] forward_a_E,
  output logic [1:0] forward_b_E,
  output logic       forward_a_D,
  output logic       forward_b_D,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_E,
  output logic       mdu_busy,
  output logic       mdu_done
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] fwd_cnt
`endif
);

  // M has priority over W: it holds the younger value of the register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (src != REG_ZERO && regwrite_M && writereg_M == src)      fwd_sel = FWD_MEM;
    else if (src != REG_ZERO && regwrite_W && writereg_W == src) fwd_sel = FWD_WB;
    else                                                         fwd_sel = FWD_REGF;
  endfunction

  logic lwstall, branchstall, mdustall, stall;
  logic e_hits_d, m_hits_d;

  assign forward_a_E = fwd_sel(rs_E);
  assign forward_b_E = fwd_sel(rt_E);

  // Branch compare in ID can only reach aluout_M; older values come via the regfile.
  assign forward_a_D = (rs_D != REG_ZERO) && regwrite_M && (writereg_M == rs_D);
  assign forward_b_D = (rt_D != REG_ZERO) && regwrite_M && (writereg_M == rt_D);

  assign e_hits_d = (writereg_E != REG_ZERO) && ((writereg_E == rs_D) || (writereg_E == rt_D));
  assign m_hits_d = (writereg_M != REG_ZERO) && ((writereg_M == rs_D) || (writereg_M == rt_D));

  assign lwstall     = memtoreg_E && e_hits_d;
  // Branch waits for an ALU result still in EX, or a load result not yet out of M.
  assign branchstall = branch_D && ((regwrite_E && e_hits_d) || (memtoreg_M && m_hits_d));
  // The in-flight start counts too: busy only rises on the following edge.
  assign mdustall    = mdu_use_D && (mdu_busy || mdu_start_E);

  assign stall   = lwstall | branchstall | mdustall;
  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;

  mdu_busy_ctr #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mdu_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .start (mdu_start_E),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_D && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((forward_a_E != FWD_REGF || forward_b_E != FWD_REGF) && fwd_cnt != 32'hFFFF_FFFF) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: table of combinational vectors plus MDU and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
  logic       regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M;
  logic       branch_D, mdu_use_D, mdu_start_E;
  logic [1:0] forward_a_E, forward_b_E;
  logic       forward_a_D, forward_b_D, stall_F, stall_D, flush_E, mdu_busy, mdu_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MDU_LATENCY(LAT), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .rs_E        (rs_E),
    .rt_E        (rt_E),
    .writereg_E  (writereg_E),
    .writereg_M  (writereg_M),
    .writereg_W  (writereg_W),
    .regwrite_E  (regwrite_E),
    .regwrite_M  (regwrite_M),
    .regwrite_W  (regwrite_W),
    .memtoreg_E  (memtoreg_E),
    .memtoreg_M  (memtoreg_M),
    .branch_D    (branch_D),
    .mdu_use_D   (mdu_use_D),
    .mdu_start_E (mdu_start_E),
    .forward_a_E (forward_a_E),
    .forward_b_E (forward_b_E),
    .forward_a_D (forward_a_D),
    .forward_b_D (forward_b_D),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_E     (flush_E),
    .mdu_busy    (mdu_busy),
    .mdu_done    (mdu_done)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  // A start while the MDU is busy should never be issued by a correct pipeline.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(mdu_start_E && mdu_busy)) else $error("mdu_start_E asserted while mdu_busy");
    end
  end

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, mr_e, mr_m, br_d, mdu_d;
    logic [1:0] fa_e, fb_e;
    logic       fa_d, fb_d, stall;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input vec_t v);
    rs_D = v.rs_d; rt_D = v.rt_d; rs_E = v.rs_e; rt_E = v.rt_e;
    writereg_E = v.wr_e; writereg_M = v.wr_m; writereg_W = v.wr_w;
    regwrite_E = v.rw_e; regwrite_M = v.rw_m; regwrite_W = v.rw_w;
    memtoreg_E = v.mr_e; memtoreg_M = v.mr_m;
    branch_D = v.br_d; mdu_use_D = v.mdu_d;
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_F"}, 32'(stall_F), 32'(exp));
    check({name, ".stall_D"}, 32'(stall_D), 32'(exp));
    check({name, ".flush_E"}, 32'(flush_E), 32'(exp));
  endtask

  initial begin
    vec_t zero_v;
    int   busy_cycles;
    bit   seen_done;

    //             rs_d  rt_d  rs_e  rt_e  wr_e  wr_m  wr_w  rwE rwM rwW mrE mrM brD mdD faE    fbE    faD fbD stl
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0,  1,  1,  0,  0,  0,  0,  2'b10, 2'b00, 0,  0,  0};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0,  0,  1,  0,  0,  0,  0,  2'b01, 2'b00, 0,  0,  0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,  1,  1,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[4]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 5'd7, 5'd7, 0,  1,  1,  0,  0,  0,  0,  2'b10, 2'b10, 0,  0,  0};
    vecs[5]  = '{5'd0, 5'd0, 5'd6, 5'd9, 5'd0, 5'd6, 5'd9, 0,  0,  1,  0,  0,  0,  0,  2'b00, 2'b01, 0,  0,  0};
    vecs[6]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1,  0,  0,  1,  0,  0,  0,  2'b00, 2'b00, 0,  0,  1};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1,  0,  0,  1,  0,  0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[8]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 0,  0,  1};
    vecs[9]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 0,  1,  0,  0,  0,  1,  0,  2'b00, 2'b00, 1,  0,  0};
    vecs[10] = '{5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 0,  1,  0,  0,  1,  1,  0,  2'b00, 2'b00, 0,  1,  1};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,  1,  0,  0,  1,  1,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[12] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,  0,  0,  0,  0,  0,  1,  2'b00, 2'b00, 0,  0,  0};
    vecs[14] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 0,  0,  1,  0,  0,  0,  0,  2'b00, 2'b00, 0,  0,  0};
    vecs[15] = '{5'd12,5'd0, 5'd0, 5'd0, 5'd12,5'd0, 5'd0, 1,  0,  0,  1,  0,  0,  0,  2'b00, 2'b00, 0,  0,  1};

    zero_v = vecs[0];
    drive(zero_v);
    mdu_start_E = 1'b0;
    reset = 1'b1;

    // Reset state with all inputs low
    step();
    step();
    @(negedge clk);
    check("rst.mdu_busy", 32'(mdu_busy), 32'd0);
    check("rst.mdu_done", 32'(mdu_done), 32'd0);
    check("rst.fwd_a_E", 32'(forward_a_E), 32'd0);
    check("rst.fwd_b_E", 32'(forward_b_E), 32'd0);
    check_stall("rst", 1'b0);
    step();
    reset = 1'b0;

    // Combinational vector table
    for (int i = 0; i < NV; i++) begin
      step();
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d.fwd_a_E", i), 32'(forward_a_E), 32'(vecs[i].fa_e));
      check($sformatf("v%0d.fwd_b_E", i), 32'(forward_b_E), 32'(vecs[i].fb_e));
      check($sformatf("v%0d.fwd_a_D", i), 32'(forward_a_D), 32'(vecs[i].fa_d));
      check($sformatf("v%0d.fwd_b_D", i), 32'(forward_b_D), 32'(vecs[i].fb_d));
      check_stall($sformatf("v%0d", i), vecs[i].stall);
    end

    // Load-use stall lasts only while the load sits in EX
    step();
    drive(vecs[6]);
    @(negedge clk);
    check_stall("lw.hit", 1'b1);
    step();
    drive(zero_v);
    @(negedge clk);
    check_stall("lw.after", 1'b0);

    // Branch: ALU producer in EX stalls, then forwards from M next cycle
    step();
    drive(vecs[8]);
    @(negedge clk);
    check_stall("br.e", 1'b1);
    step();
    drive(vecs[9]);
    @(negedge clk);
    check_stall("br.m", 1'b0);
    check("br.m.fwd_a_D", 32'(forward_a_D), 32'd1);

    // MDU op with a dependent instruction held in ID
    step();
    drive(zero_v);
    mdu_start_E = 1'b1;
    mdu_use_D   = 1'b1;
    @(negedge clk);
    check("mdu.c0.busy", 32'(mdu_busy), 32'd0);
    check_stall("mdu.c0", 1'b1);
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      if (c == 1) mdu_start_E = 1'b0;
      @(negedge clk);
      check($sformatf("mdu.c%0d.busy", c), 32'(mdu_busy), 32'(c <= LAT));
      check($sformatf("mdu.c%0d.done", c), 32'(mdu_done), 32'(c == LAT));
      check($sformatf("mdu.c%0d.stall_D", c), 32'(stall_D), 32'(c <= LAT));
    end
    mdu_use_D = 1'b0;

    // Reset in the middle of an MDU op, then an immediate restart
    step();
    mdu_start_E = 1'b1;
    step();
    mdu_start_E = 1'b0;
    @(negedge clk);
    check("mrst.c1.busy", 32'(mdu_busy), 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("mrst.c2.busy", 32'(mdu_busy), 32'd1);
    check("mrst.c2.done", 32'(mdu_done), 32'd0);
    step();
    reset = 1'b0;
    mdu_start_E = 1'b1;
    @(negedge clk);
    check("mrst.c3.busy", 32'(mdu_busy), 32'd0);
    check("mrst.c3.done", 32'(mdu_done), 32'd0);
    step();
    mdu_start_E = 1'b0;
    busy_cycles = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 10 && !seen_done; k++) begin
      @(negedge clk);
      if (mdu_busy) busy_cycles++;
      if (mdu_done) seen_done = 1'b1;
      else step();
    end
    check("mrst.done_seen", 32'(seen_done), 32'd1);
    check("mrst.busy_cycles", 32'(busy_cycles), 32'(LAT));
    step();
    @(negedge clk);
    check("mrst.idle", 32'(mdu_busy), 32'd0);

`ifdef HAZARD_STATS_EN
    // Counters: clear, 3 load-use stall cycles, 2 forwarding cycles, then clear again
    step();
    drive(zero_v);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("stats.clr.stall_cnt", stall_cnt, 32'd0);
    check("stats.clr.fwd_cnt", fwd_cnt, 32'd0);
    step();
    drive(vecs[6]);
    step();
    step();
    step();
    drive(vecs[1]);
    step();
    step();
    drive(zero_v);
    @(negedge clk);
    check("stats.stall_cnt", stall_cnt, 32'd3);
    check("stats.fwd_cnt", fwd_cnt, 32'd2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("stats.rst.stall_cnt", stall_cnt, 32'd0);
    check("stats.rst.fwd_cnt", fwd_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
